decrementor: RTL and testbench
==============================

# decrementor

Down-counting companion to the incrementor: holds a WIDTH-bit count that is loaded with a start value and reduced by STEP on each `dec` request, saturating at zero. A small state machine reports when the count has been exhausted and flags any request that would have gone below zero. It sits downstream of the incrementor-style counters as a budget/countdown register, using the same clock and `clr` conventions.

## Interface
- `WIDTH`, 32, width of the count and load value
- `STEP`, 3, amount subtracted per accepted `dec`; must be 1..2^WIDTH-1

- `clk`  in  1  clock; all state changes on rising edge
- `clr`  in  1  reset, synchronous, active-high
- `load`  in  1  load `load_value` into the count this cycle
- `load_value`  in  WIDTH  start value for the countdown
- `dec`  in  1  request one decrement by STEP
- `value`  out  WIDTH  current count (registered)
- `done`  out  1  level: state is EXPIRED
- `expired`  out  1  one-cycle pulse on the ARMED->EXPIRED transition
- `underflow`  out  1  sticky: a decrement request could not be fully satisfied

## Operation
- States: IDLE, ARMED, EXPIRED (2-bit encoding, implementation's choice).
- Priority per edge: `clr` > `load` > `dec`.
- `clr`=1: `value`=0, state IDLE, `done`=0, `expired`=0, `underflow`=0, regardless of other inputs.
- `load`=1 (any state): `value`<=`load_value`; `underflow`<=0; `expired`<=0; next state ARMED if `load_value`!=0, else EXPIRED (no `expired` pulse on a load of zero). `dec` in the same cycle is ignored.
- IDLE, `dec`=1: ignored; `value` stays 0, `underflow` unchanged.
- ARMED, `dec`=1:
  - `value` > STEP: `value`<=`value`-STEP, stay ARMED.
  - `value` == STEP: `value`<=0, go EXPIRED, `expired` pulses; `underflow` unchanged.
  - `value` < STEP: `value`<=0, go EXPIRED, `expired` pulses, `underflow`<=1.
- EXPIRED, `dec`=1: `value` stays 0, `underflow`<=1, no new `expired` pulse.
- `dec`=0 and `load`=0: all state holds; `expired` returns to 0.
- Arithmetic is unsigned WIDTH-bit. The comparison against STEP is performed before subtraction so `value` never wraps. STEP is truncated to WIDTH bits.
- `done` is 1 exactly when the state is EXPIRED.

## Timing
- All outputs are registered. Effects of `load`, `dec`, and `clr` are visible one cycle after the sampling edge.
- `dec` is a level sampled every edge: holding it high for N cycles requests N decrements, with no handshake or back-pressure.
- `expired` is high for exactly one cycle, the cycle after `value` reaches 0 from ARMED. `done` rises in the same cycle.
- Reset mid-countdown takes effect at the next edge, discarding the count. Reset is not required to be held for more than one cycle.
- Values after reset: `value`=0, `done`=0, `expired`=0, `underflow`=0, state IDLE.

## Test plan
- Reset: assert `clr` for 1 cycle with `dec`=1 and `load`=1 -> all outputs 0, state IDLE. `dec` with no load -> `value` stays 0, `underflow`=0.
- Exact countdown: load 9, then `dec` high for 3 cycles -> `value` goes 9,6,3,0. `expired` pulses once with `done`=1. `underflow`=0.
- Partial underflow: load 7, then 3 `dec` cycles -> `value` goes 7,4,1,0. `underflow`=1 after the third `dec`. `expired` pulses once.
- Saturation: in EXPIRED, issue 2 more `dec` -> `value` stays 0, no `expired` pulse, `underflow` stays 1. Then load 0 -> `done`=1, no pulse, `underflow`=0.
- Priority: in ARMED with `value`=10, drive `load`=1 with `load_value`=100 and `dec`=1 -> `value`=100. The next `dec` gives 97. Asserting `clr` with `load`=1 -> `value`=0.
- Width edge: load 32'hFFFFFFFF with `dec` held -> first steps FFFFFFFC, FFFFFFF9. Load 2 then `dec` -> `value`=0, `underflow`=1, no wrap to FFFFFFFF.

Source files
------------

// File: rtl/decrementor.sv
// Saturating countdown register with expiry tracking.
// Loaded with a start value, reduced by STEP per dec, never wraps below zero.
module decrementor #(
    parameter int WIDTH = 32,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             done,
    output logic             expired,
    output logic             underflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        EXPIRED = 2'b10
    } state_t;

    // Step is truncated to the count width.
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t state;

    // Countdown FSM; clr beats load, load beats dec, outputs registered.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            value     <= '0;
            done      <= 1'b0;
            expired   <= 1'b0;
            underflow <= 1'b0;
        end else if (load) begin
            value     <= load_value;
            underflow <= 1'b0;
            expired   <= 1'b0;
            if (load_value != '0) begin
                state <= ARMED;
                done  <= 1'b0;
            end else begin
                state <= EXPIRED;
                done  <= 1'b1;
            end
        end else if (dec) begin
            expired <= 1'b0;
            unique case (state)
                IDLE: begin
                    value <= '0;
                end
                ARMED: begin
                    // Compare first so the subtraction can never wrap.
                    if (value > STEP_W) begin
                        value <= value - STEP_W;
                    end else begin
                        value   <= '0;
                        state   <= EXPIRED;
                        done    <= 1'b1;
                        expired <= 1'b1;
                        if (value < STEP_W) begin
                            underflow <= 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    value     <= '0;
                    underflow <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    value <= '0;
                    done  <= 1'b0;
                end
            endcase
        end else begin
            expired <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decrementor.sv
// Randomized scoreboard bench for decrementor.
// Reference model tracks remaining budget with plain integer arithmetic.
module tb_decrementor;

    localparam int WIDTH = 32;
    localparam int STEP  = 3;

    logic             clk;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             dec;
    logic [WIDTH-1:0] value;
    logic             done;
    logic             expired;
    logic             underflow;

    decrementor #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .clr       (clr),
        .load      (load),
        .load_value(load_value),
        .dec       (dec),
        .value     (value),
        .done      (done),
        .expired   (expired),
        .underflow (underflow)
    );

    typedef struct {
        longint v;
        bit     d;
        bit     e;
        bit     u;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;

    // model state
    longint m_val  = 0;
    bit     m_live = 0;
    bit     m_done = 0;
    bit     m_puls = 0;
    bit     m_uf   = 0;
    longint mask   = (longint'(1) << WIDTH) - 1;
    longint m_step;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("value", 64'(value), 64'(mon_e.v));
            chk("done", 64'(done), 64'(mon_e.d));
            chk("expired", 64'(expired), 64'(mon_e.e));
            chk("underflow", 64'(underflow), 64'(mon_e.u));
        end
    end

    task automatic model(input bit c, input bit l, input longint lv,
                         input bit d);
        if (c) begin
            m_val = 0; m_live = 0; m_done = 0; m_puls = 0; m_uf = 0;
        end else if (l) begin
            m_val  = lv & mask;
            m_uf   = 0;
            m_puls = 0;
            m_live = (m_val != 0);
            m_done = (m_val == 0);
        end else if (d && m_live) begin
            if (m_val < m_step) m_uf = 1;
            m_val  = (m_val > m_step) ? m_val - m_step : 0;
            m_puls = (m_val == 0);
            if (m_val == 0) begin
                m_live = 0;
                m_done = 1;
            end
        end else if (d && m_done) begin
            m_uf   = 1;
            m_puls = 0;
        end else begin
            m_puls = 0;
        end
    endtask

    task automatic step(input bit c, input bit l, input logic [WIDTH-1:0] lv,
                        input bit d);
        exp_t e;
        clr        = c;
        load       = l;
        load_value = lv;
        dec        = d;
        @(posedge clk);
        model(c, l, longint'(lv), d);
        e.v = m_val; e.d = m_done; e.e = m_puls; e.u = m_uf;
        q.push_back(e);
        #2;
    endtask

    initial begin
        m_step     = longint'(STEP) & mask;
        clr        = 1'b0;
        load       = 1'b0;
        load_value = '0;
        dec        = 1'b0;
        #2;

        // reset dominates load and dec
        step(1, 1, 32'd55, 1);
        chk("rst_value", 64'(value), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        step(0, 0, 0, 1);
        chk("idle_dec_uf", 64'(underflow), 64'd0);

        // exact countdown 9,6,3,0
        step(0, 1, 32'd9, 0);
        repeat (3) step(0, 0, 0, 1);
        chk("exact_zero", 64'(value), 64'd0);
        chk("exact_pulse", 64'(expired), 64'd1);
        chk("exact_uf", 64'(underflow), 64'd0);

        // partial underflow 7,4,1,0
        step(0, 1, 32'd7, 0);
        repeat (3) step(0, 0, 0, 1);
        chk("part_uf", 64'(underflow), 64'd1);

        // saturation, then load zero
        repeat (2) step(0, 0, 0, 1);
        chk("sat_nopulse", 64'(expired), 64'd0);
        step(0, 1, 32'd0, 0);
        chk("load0_done", 64'(done), 64'd1);
        chk("load0_uf", 64'(underflow), 64'd0);

        // priority
        step(0, 1, 32'd10, 0);
        step(0, 1, 32'd100, 1);
        chk("prio_load", 64'(value), 64'd100);
        step(0, 0, 0, 1);
        chk("prio_dec", 64'(value), 64'd97);
        step(1, 1, 32'd5, 0);
        chk("prio_clr", 64'(value), 64'd0);

        // width edge
        step(0, 1, 32'hFFFF_FFFF, 1);
        step(0, 0, 0, 1);
        chk("w_ffc", 64'(value), 64'hFFFF_FFFC);
        step(0, 0, 0, 1);
        chk("w_ff9", 64'(value), 64'hFFFF_FFF9);
        step(0, 1, 32'd2, 0);
        step(0, 0, 0, 1);
        chk("nowrap", 64'(value), 64'd0);
        chk("nowrap_uf", 64'(underflow), 64'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit c, l, d;
            logic [WIDTH-1:0] lv;
            c  = ($urandom_range(0, 99) < 2);
            l  = ($urandom_range(0, 99) < 12);
            d  = ($urandom_range(0, 99) < 65);
            lv = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom)
                                             : WIDTH'($urandom_range(0, 25));
            step(c, l, lv, d);
        end

        step(0, 0, 0, 0);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
